// File: rtl/regfile_write_arbiter_if.sv
// Handshake bundle between writeback requesters and the register-file write arbiter,
// including the registered write port that feeds the register file.
interface regfile_write_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 8,
  parameter int RW   = 2
) ();
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*RW-1:0] req_reg;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               write_en;
  logic [RW-1:0]      write_reg;
  logic [DW-1:0]      write_value;
  logic [IW-1:0]      grant_id;

  modport master (
    output req_valid, req_lock, req_reg, req_data,
    input  req_ready, write_en, write_reg, write_value, grant_id
  );

  modport slave (
    input  req_valid, req_lock, req_reg, req_data,
    output req_ready, write_en, write_reg, write_value, grant_id
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a bounded
// lock so one source can stream a short burst; the write port is fully registered.
module regfile_write_arbiter #(
  parameter int NREQ     = 3,
  parameter int DW       = 8,
  parameter int RW       = 2,
  parameter int MAX_LOCK = 4
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

  logic [IW-1:0]   ptr_q, ptr_d;
  logic            lock_vld_q, lock_vld_d;
  logic [IW-1:0]   lock_id_q, lock_id_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            write_en_q, write_en_d;
  logic [RW-1:0]   write_reg_q, write_reg_d;
  logic [DW-1:0]   write_value_q, write_value_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;

  logic            gnt_vld_s;
  logic [IW-1:0]   gnt_id_s;
  logic [IW-1:0]   cand_s;
  logic [NREQ-1:0] ready_s;
  logic            same_owner_s;
  logic            keep_lock_s;
  int              burst_s;

  // Grant selection: lock holder first, otherwise first valid requester from ptr.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_id_s  = '0;
    cand_s    = '0;
    if (lock_vld_q && bus.req_valid[lock_id_q] && (int'(lock_cnt_q) < MAX_LOCK - 32'sd1)) begin
      gnt_vld_s = 1'b1;
      gnt_id_s  = lock_id_q;
    end else begin
      // Scan farthest offset first so the nearest valid requester overwrites last.
      for (int k = NREQ - 1; k >= 0; k--) begin
        cand_s    = IW'((int'(ptr_q) + k) % NREQ);
        gnt_id_s  = bus.req_valid[cand_s] ? cand_s : gnt_id_s;
        gnt_vld_s = gnt_vld_s | bus.req_valid[cand_s];
      end
    end
  end

  // One-hot ready, forced low while reset is asserted.
  always_comb begin
    ready_s           = '0;
    ready_s[gnt_id_s] = gnt_vld_s & ~reset;
  end

  assign bus.req_ready = ready_s;

  // Next arbitration state and registered write-port values.
  always_comb begin
    ptr_d         = ptr_q;
    lock_vld_d    = 1'b0;
    lock_id_d     = lock_id_q;
    lock_cnt_d    = lock_cnt_q;
    write_en_d    = gnt_vld_s;
    write_reg_d   = write_reg_q;
    write_value_d = write_value_q;
    grant_id_d    = grant_id_q;
    same_owner_s  = lock_vld_q && (lock_id_q == gnt_id_s);
    // Position of this grant within the current locked burst (1-based).
    burst_s       = same_owner_s ? int'(lock_cnt_q) + 32'sd2 : 32'sd1;
    keep_lock_s   = gnt_vld_s && bus.req_lock[gnt_id_s] && (burst_s < MAX_LOCK);

    if (keep_lock_s) begin
      lock_vld_d = 1'b1;
      lock_id_d  = gnt_id_s;
      lock_cnt_d = same_owner_s ? (lock_cnt_q + CW'(1)) : '0;
    end else if (gnt_vld_s) begin
      lock_cnt_d = '0;
      ptr_d      = (gnt_id_s == IW'(NREQ - 1)) ? '0 : (gnt_id_s + IW'(1));
    end else begin
      lock_vld_d = 1'b0;
    end

    if (gnt_vld_s) begin
      write_reg_d   = bus.req_reg[gnt_id_s * RW +: RW];
      write_value_d = bus.req_data[gnt_id_s * DW +: DW];
      grant_id_d    = gnt_id_s;
    end else begin
      grant_id_d    = grant_id_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q         <= '0;
      lock_vld_q    <= 1'b0;
      lock_id_q     <= '0;
      lock_cnt_q    <= '0;
      write_en_q    <= 1'b0;
      write_reg_q   <= '0;
      write_value_q <= '0;
      grant_id_q    <= '0;
    end else begin
      ptr_q         <= ptr_d;
      lock_vld_q    <= lock_vld_d;
      lock_id_q     <= lock_id_d;
      lock_cnt_q    <= lock_cnt_d;
      write_en_q    <= write_en_d;
      write_reg_q   <= write_reg_d;
      write_value_q <= write_value_d;
      grant_id_q    <= grant_id_d;
    end
  end

  assign bus.write_en    = write_en_q;
  assign bus.write_reg   = write_reg_q;
  assign bus.write_value = write_value_q;
  assign bus.grant_id    = grant_id_q;
endmodule
